// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial pattern transmitter with repeat count and start/busy/done handshake; define SERIAL_PATTERN_GEN_RUN3_EN to add the run3 output
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
    output logic             run3,
`endif
    output logic [1:0]       current
);
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
    localparam logic [LEN_W-1:0] W_FULL = LEN_W'(WIDTH);
    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_sr;
    logic [LEN_W-1:0] r_bits;
    logic [LEN_W-1:0] r_last;
    logic [REP_W-1:0] r_rep;
    logic             r_out;
    logic             r_valid;
    logic             r_done;
    logic [LEN_W-1:0] w_len;
    logic [WIDTH-1:0] w_shadow;
    logic             w_wrap;
    logic             w_fin;
    logic             w_nb;
    assign w_len    = (len == '0 || len > W_FULL) ? W_FULL : len;
    assign w_shadow = pattern << (W_FULL - w_len);
    assign w_wrap   = r_bits == '0;
    assign w_fin    = w_wrap && r_rep == '0;
    assign w_nb     = w_wrap ? r_shadow[WIDTH-1] : r_sr[WIDTH-2];
    assign out      = r_out;
    assign valid    = r_valid;
    assign done     = r_done;
    assign busy     = r_state != IDLE;
    assign current  = r_state;
    // frame sequencer: accept in IDLE, shift and reload passes back to back in SHIFT, pulse done once
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_sr     <= '0;
            r_bits   <= '0;
            r_last   <= '0;
            r_rep    <= '0;
            r_out    <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_out   <= start & w_shadow[WIDTH-1];
                    r_valid <= start;
                    if (start) begin
                        r_shadow <= w_shadow;
                        r_sr     <= w_shadow;
                        r_last   <= w_len - 1'b1;
                        r_bits   <= w_len - 1'b1;
                        r_rep    <= reps;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_out   <= !w_fin & w_nb;
                    r_valid <= !w_fin;
                    r_done  <= w_fin;
                    r_sr    <= w_wrap ? r_shadow : r_sr << 1;
                    r_bits  <= w_wrap ? r_last : r_bits - 1'b1;
                    r_rep   <= (w_wrap && !w_fin) ? r_rep - 1'b1 : r_rep;
                    r_state <= w_fin ? DONE : SHIFT;
                end
                default: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
    logic [1:0] r_hist;
    logic       r_run3;
    assign run3 = r_run3;
    // track the last two sent bits; history restarts in IDLE so a run never spans frames
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= '0;
            r_run3 <= 1'b0;
        end else if (r_state == IDLE) begin
            r_hist <= {1'b0, start & w_shadow[WIDTH-1]};
            r_run3 <= 1'b0;
        end else if (r_state == SHIFT && !w_fin) begin
            r_hist <= {r_hist[0], w_nb};
            r_run3 <= w_nb & r_hist[0] & r_hist[1];
        end else begin
            r_run3 <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: scoreboard bench for serial_pattern_gen
module tb_serial_pattern_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] reps = '0;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] current;
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
    logic       run3;
`endif
    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_q[$];
    logic obs_q[$];
    logic exp_r3[$];
    logic obs_r3[$];
    int   first_v, last_v, n_v, done_at, n_busy;
    bit   timed_out;
    logic e, o;

    always #5 clk = ~clk;

    serial_pattern_gen dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .len(len),
        .reps(reps),
        .out(out),
        .valid(valid),
        .busy(busy),
        .done(done),
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
        .run3(run3),
`endif
        .current(current)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // push the expected frame to the scoreboard, then present start for one accept edge
    task automatic kick(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input bit hold);
        int   n;
        logic h1, h0;
        n = (l == 0 || l > 8) ? 8 : int'(l);
        h1 = 1'b0;
        h0 = 1'b0;
        exp_r3.delete();
        for (int k = 0; k <= int'(r); k++)
            for (int i = n - 1; i >= 0; i--) begin
                exp_q.push_back(p[i]);
                exp_r3.push_back(p[i] & h1 & h0);
                h1 = h0;
                h0 = p[i];
            end
        pattern = p;
        len = l;
        reps = r;
        start = 1'b1;
        tick();
        start = hold;
    endtask

    // record DUT output cycle by cycle until done or the budget runs out
    task automatic collect(input int budget);
        obs_q.delete();
        obs_r3.delete();
        n_v = 0;
        first_v = -1;
        last_v = -1;
        done_at = -1;
        n_busy = 0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (busy) n_busy++;
            if (valid) begin
                obs_q.push_back(out);
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
                obs_r3.push_back(run3);
`endif
                n_v++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (done) begin
                done_at = c;
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_chk++; if (current !== 2'b00) $display("FAIL reset_current got=%b exp=00", current); else n_pass++;
        n_chk++; if (out !== 1'b0) $display("FAIL reset_out got=%b exp=0", out); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        reset = 1'b1;
        tick();
        n_chk++; if (current !== 2'b00) $display("FAIL idle_current got=%b exp=00", current); else n_pass++;
    endtask

    task automatic test_basic();
        kick(8'hB4, 4'd8, 4'd0, 1'b0);
        pattern = 8'h00;
        len = 4'd1;
        reps = 4'hF;
        collect(64);
        n_chk++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got=%b exp=0", timed_out); else n_pass++;
        n_chk++; if (first_v !== 0) $display("FAIL basic_latency got=%0d exp=0", first_v); else n_pass++;
        n_chk++; if (n_v !== 8) $display("FAIL basic_nvalid got=%0d exp=8", n_v); else n_pass++;
        n_chk++; if (last_v !== 7) $display("FAIL basic_contig got=%0d exp=7", last_v); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL basic_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        n_chk++; if (done_at !== 8) $display("FAIL basic_done_at got=%0d exp=8", done_at); else n_pass++;
        n_chk++; if (n_busy !== 9) $display("FAIL basic_busy_cycles got=%0d exp=9", n_busy); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0 || current !== 2'b00) $display("FAIL basic_back_idle got=%b/%b exp=0/00", busy, current); else n_pass++;
    endtask

    task automatic test_repeats();
        kick(8'h05, 4'd3, 4'd2, 1'b0);
        collect(64);
        n_chk++; if (n_v !== 9 || last_v - first_v !== 8) $display("FAIL rep_nvalid got=%0d span=%0d exp=9 span=8", n_v, last_v - first_v); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL rep_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        n_chk++; if (done_at !== 9) $display("FAIL rep_done_at got=%0d exp=9", done_at); else n_pass++;
        tick();
    endtask

    task automatic test_len_edges();
        kick(8'hFF, 4'd0, 4'd0, 1'b0);
        collect(64);
        n_chk++; if (n_v !== 8 || done_at !== 8) $display("FAIL zero_len got=%0d/%0d exp=8/8", n_v, done_at); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL zero_len_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
        kick(8'h96, 4'd12, 4'd0, 1'b0);
        collect(64);
        n_chk++; if (n_v !== 8 || done_at !== 8) $display("FAIL over_len got=%0d/%0d exp=8/8", n_v, done_at); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL over_len_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
        kick(8'hA3, 4'd1, 4'd2, 1'b0);
        collect(64);
        n_chk++; if (n_v !== 3 || done_at !== 3) $display("FAIL len1 got=%0d/%0d exp=3/3", n_v, done_at); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL len1_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
    endtask

    task automatic test_max_reps();
        kick(8'h02, 4'd2, 4'hF, 1'b0);
        collect(128);
        n_chk++; if (n_v !== 32 || last_v !== 31) $display("FAIL maxrep_nvalid got=%0d last=%0d exp=32 last=31", n_v, last_v); else n_pass++;
        n_chk++; if (done_at !== 32 || n_busy !== 33) $display("FAIL maxrep_done got=%0d busy=%0d exp=32 busy=33", done_at, n_busy); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL maxrep_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        kick(8'h2D, 4'd6, 4'd0, 1'b1);
        collect(64);
        n_chk++; if (n_v !== 6 || done_at !== 6) $display("FAIL hold_frame got=%0d/%0d exp=6/6", n_v, done_at); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL hold_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
        n_chk++; if (current !== 2'b00 || valid !== 1'b0) $display("FAIL hold_idle_gap got=%b/%b exp=00/0", current, valid); else n_pass++;
        kick(8'h2D, 4'd6, 4'd0, 1'b0);
        n_chk++; if (current !== 2'b01 || valid !== 1'b1) $display("FAIL hold_restart got=%b/%b exp=01/1", current, valid); else n_pass++;
        collect(64);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_chk++; if (o !== e) $display("FAIL hold2_bit%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        bit bad;
        seen = 0;
        kick(8'hA5, 4'd8, 4'd2, 1'b0);
        for (int c = 0; c < 40 && seen < 5; c++) begin
            if (valid) begin
                e = exp_q.pop_front();
                n_chk++; if (out !== e) $display("FAIL mid_bit%0d got=%b exp=%b", seen, out, e); else n_pass++;
                seen++;
            end
            if (seen < 5) tick();
        end
        n_chk++; if (seen !== 5) $display("FAIL mid_reach5 got=%0d exp=5", seen); else n_pass++;
        reset = 1'b0;
        tick();
        n_chk++; if (current !== 2'b00) $display("FAIL mid_current got=%b exp=00", current); else n_pass++;
        n_chk++; if (valid !== 1'b0 || out !== 1'b0) $display("FAIL mid_valid_out got=%b/%b exp=0/0", valid, out); else n_pass++;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_busy_done got=%b/%b exp=0/0", busy, done); else n_pass++;
        reset = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0) $display("FAIL mid_no_done got=%b exp=0", bad); else n_pass++;
        exp_q.delete();
    endtask

`ifdef SERIAL_PATTERN_GEN_RUN3_EN
    task automatic test_run3();
        kick(8'h77, 4'd8, 4'd0, 1'b0);
        collect(64);
        n_chk++; if (run3 !== 1'b0) $display("FAIL run3_done_cycle got=%b exp=0", run3); else n_pass++;
        for (int i = 0; exp_r3.size() > 0; i++) begin
            e = exp_r3.pop_front();
            o = 1'bx;
            if (obs_r3.size() > 0) o = obs_r3.pop_front();
            n_chk++; if (o !== e) $display("FAIL run3_idx%0d got=%b exp=%b", i, o, e); else n_pass++;
        end
        exp_q.delete();
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_repeats();
        test_len_edges();
        test_max_reps();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_PATTERN_GEN_RUN3_EN
        test_run3();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
